// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder.
// Provides scan-code constants, the key-class and parser-state enums, the
// event record stored in the FIFO, and small decode helpers.
package ps2_pkg;

  localparam logic [7:0] ScUp    = 8'h1D;
  localparam logic [7:0] ScDown  = 8'h1B;
  localparam logic [7:0] ScLeft  = 8'h1C;
  localparam logic [7:0] ScRight = 8'h23;
  localparam logic [7:0] ScEnter = 8'h5A;
  localparam logic [7:0] ScEsc   = 8'h76;
  localparam logic [7:0] ScMove  = 8'h3A;
  localparam logic [7:0] ScE0    = 8'hE0;
  localparam logic [7:0] ScF0    = 8'hF0;
  localparam logic [7:0] ScAA    = 8'hAA;
  localparam logic [7:0] ScFA    = 8'hFA;
  localparam logic [7:0] ScFE    = 8'hFE;

  typedef enum logic [2:0] {
    KeyUp, KeyDown, KeyLeft, KeyRight, KeyEnter, KeyEsc, KeyMove, KeyOther
  } key_class_e;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} parse_state_e;

  // 12-bit FIFO entry {key, ext, code}
  typedef struct packed {
    key_class_e  key;
    logic        ext;
    logic [7:0]  code;
  } key_event_t;

  // Class depends on the code byte only; the E0 prefix is ignored.
  function automatic key_class_e classify(input logic [7:0] code);
    key_class_e k;
    case (code)
      ScUp:    k = KeyUp;
      ScDown:  k = KeyDown;
      ScLeft:  k = KeyLeft;
      ScRight: k = KeyRight;
      ScEnter: k = KeyEnter;
      ScEsc:   k = KeyEsc;
      ScMove:  k = KeyMove;
      default: k = KeyOther;
    endcase
    return k;
  endfunction

  // Keyboard status/ack bytes that carry no key information outside a prefix.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == ScAA) || (b == ScFA) || (b == ScFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small event FIFO with a registered head.
// Implemented as a shift register: slot 0 is always the head, so every head
// output comes straight from a flop.
// Ports:
//   clk50, RST        clock, asynchronous active-low reset
//   push, push_data   write request and entry (dropped when full without pop)
//   pop               remove the head (ignored when empty)
//   full, empty       occupancy flags
//   head_valid, head  registered head entry
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk50,
  input  logic       RST,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic       head_valid,
  output key_event_t head
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  key_event_t     mem_q [DEPTH];
  key_event_t     mem_d [DEPTH];
  logic [CntW-1:0] cnt_q, cnt_d, wr_ptr;
  logic            valid_q;
  logic            pop_en, push_en;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_en  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);

  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    wr_ptr = cnt_q;
    if (pop_en) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d  = cnt_q - CntW'(1);
      wr_ptr = cnt_q - CntW'(1);
    end
    if (push_en) begin
      mem_d[wr_ptr[IdxW-1:0]] = push_data;
      cnt_d = cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk50 or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  assign head_valid = valid_q;
  assign head       = mem_q[0];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-byte to key-event decoder.
// Tracks E0/F0 prefixes, suppresses typematic repeats of the held key,
// classifies chess-control keys and queues events for a ready/valid consumer.
// Ports:
//   clk50, RST          clock, asynchronous active-low reset
//   rx_byte, rx_valid   incoming scan byte and its one-cycle strobe
//   ev_valid, ev_ready  event handshake (head accepted when both high)
//   ev_key, ev_code     head event class and raw make code
//   ev_ext              head event was E0-prefixed
//   overflow            sticky: an event was dropped on a full FIFO
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned PREFIX_TIMEOUT  = 1000000,
  parameter int unsigned SUPPRESS_REPEAT = 1
) (
  input  logic       clk50,
  input  logic       RST,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_key,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       overflow
);

  localparam int unsigned TmoW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

  parse_state_e    state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            held_valid_q, held_valid_d;
  logic            held_ext_q, held_ext_d;
  logic [7:0]      held_code_q, held_code_d;
  logic            overflow_q;

  logic       is_make, is_break, code_ext;
  logic       held_hit, accept, drop;
  logic       fifo_full, fifo_empty, fifo_pop;
  key_event_t push_ev, head_ev;

  // Parser and prefix timeout
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    is_make  = 1'b0;
    is_break = 1'b0;
    code_ext = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte == ScE0) begin
            state_d = StExt;
          end else if (rx_byte == ScF0) begin
            state_d = StBrk;
          end else if (!is_filler(rx_byte)) begin
            is_make = 1'b1;
          end
        end
        StExt: begin
          if (rx_byte == ScF0) begin
            state_d = StExtBrk;
          end else if (rx_byte != ScE0) begin
            is_make  = 1'b1;
            code_ext = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          is_break = 1'b1;
          state_d  = StIdle;
        end
        StExtBrk: begin
          is_break = 1'b1;
          code_ext = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A stale prefix is abandoned silently so a lost code byte cannot
      // reinterpret the next key.
      if (tmo_q == TmoW'(PREFIX_TIMEOUT - 1)) begin
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Held key: repeat suppression and break matching
  assign held_hit = held_valid_q && (held_ext_q == code_ext) && (held_code_q == rx_byte);
  assign accept   = is_make && !((SUPPRESS_REPEAT != 0) && held_hit);

  always_comb begin
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    if (accept) begin
      held_valid_d = 1'b1;
      held_ext_d   = code_ext;
      held_code_d  = rx_byte;
    end else if (is_break && held_hit) begin
      held_valid_d = 1'b0;
    end
  end

  assign push_ev.key  = classify(rx_byte);
  assign push_ev.ext  = code_ext;
  assign push_ev.code = rx_byte;

  assign fifo_pop = ev_ready && !fifo_empty;
  assign drop     = accept && fifo_full && !fifo_pop;

  always_ff @(posedge clk50 or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk50      (clk50),
    .RST        (RST),
    .push       (accept),
    .push_data  (push_ev),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (ev_valid),
    .head       (head_ev)
  );

  assign ev_key   = head_ev.key;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign overflow = overflow_q;

endmodule
